// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

   localparam int DEFAULT_XLEN = 64;

   // addi x0, x0, 0: the canonical RISC-V NOP used for pipeline bubbles.
   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      SKID  = 2'd1,
      DROP  = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and imem.
interface fetch_stage_if #(
   parameter int XLEN = fetch_pkg::DEFAULT_XLEN
) ();

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic [31:0]     imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: bubble (clear to NOP) takes priority over load; otherwise holds.
module ifid_reg
   import fetch_pkg::*;
#(
   parameter int XLEN = DEFAULT_XLEN
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            load,
   input  logic            bubble,
   input  logic [XLEN-1:0] pc_in,
   input  logic [31:0]     instr_in,
   output logic            valid,
   output logic [XLEN-1:0] pc,
   output logic [31:0]     instr
);

   // Bubble inserts an invalid NOP, load captures a new instruction, neither holds.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid <= 1'b0;
         pc    <= '0;
         instr <= NOP_INSTR;
      end else if (bubble) begin
         valid <= 1'b0;
         pc    <= '0;
         instr <= NOP_INSTR;
      end else if (load) begin
         valid <= 1'b1;
         pc    <= pc_in;
         instr <= instr_in;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to imem over req/ack, drives IF/ID.
// A one-entry skid buffer catches a response that lands during a stall; a flush
// with a request in flight parks in DROP until the stale response is discarded.
// Optional build macro FETCH_PERF_EN adds stall-cycle and flush counters.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int              XLEN     = DEFAULT_XLEN,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             stall,
   input  logic             flush,
   input  logic [XLEN-1:0]  branch_target,
   fetch_stage_if.master    imem,
   output logic             ifid_valid,
   output logic [XLEN-1:0]  ifid_pc,
   output logic [31:0]      ifid_instr
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]      perf_stall_cycles,
   output logic [31:0]      perf_flushes
`endif
);

   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   fetch_state_t    state;
   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] redirect_pc;
   logic [XLEN-1:0] skid_pc;
   logic [31:0]     skid_instr;

   logic            ifid_load;
   logic            ifid_bubble;
   logic [XLEN-1:0] ifid_pc_in;
   logic [31:0]     ifid_instr_in;

   // The memory port depends only on registered state, never on stall/flush.
   assign imem.imem_req  = (state != SKID);
   assign imem.imem_addr = fetch_pc;

   // IF/ID control: flush always bubbles; stall always holds; otherwise fill or bubble.
   always_comb begin
      ifid_load     = 1'b0;
      ifid_bubble   = 1'b0;
      ifid_pc_in    = fetch_pc;
      ifid_instr_in = imem.imem_rdata;
      unique case (state)
         FETCH: begin
            if (flush) begin
               ifid_bubble = 1'b1;
            end else if (!stall) begin
               if (imem.imem_ack) ifid_load   = 1'b1;
               else               ifid_bubble = 1'b1;
            end
         end
         SKID: begin
            if (flush) begin
               ifid_bubble = 1'b1;
            end else if (!stall) begin
               ifid_load     = 1'b1;
               ifid_pc_in    = skid_pc;
               ifid_instr_in = skid_instr;
            end
         end
         DROP: begin
            if (flush || !stall) ifid_bubble = 1'b1;
         end
         default: ifid_bubble = 1'b1;
      endcase
   end

   // Fetch FSM: PC advance, skid capture, and flush redirection (flush wins over stall).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= FETCH;
         fetch_pc    <= RESET_PC;
         redirect_pc <= '0;
         skid_pc     <= '0;
         skid_instr  <= '0;
      end else begin
         unique case (state)
            FETCH: begin
               if (flush) begin
                  if (imem.imem_ack) begin
                     fetch_pc <= branch_target;
                  end else begin
                     redirect_pc <= branch_target;
                     state       <= DROP;
                  end
               end else if (imem.imem_ack) begin
                  fetch_pc <= fetch_pc + PC_STEP;
                  if (stall) begin
                     skid_pc    <= fetch_pc;
                     skid_instr <= imem.imem_rdata;
                     state      <= SKID;
                  end
               end
            end
            SKID: begin
               if (flush) begin
                  skid_pc    <= '0;
                  skid_instr <= '0;
                  fetch_pc   <= branch_target;
                  state      <= FETCH;
               end else if (!stall) begin
                  state <= FETCH;
               end
            end
            DROP: begin
               if (flush) begin
                  redirect_pc <= branch_target;
               end else if (imem.imem_ack) begin
                  fetch_pc <= redirect_pc;
                  state    <= FETCH;
               end
            end
            default: state <= FETCH;
         endcase
      end
   end

   ifid_reg #(
      .XLEN (XLEN)
   ) u_ifid_reg (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (ifid_load),
      .bubble   (ifid_bubble),
      .pc_in    (ifid_pc_in),
      .instr_in (ifid_instr_in),
      .valid    (ifid_valid),
      .pc       (ifid_pc),
      .instr    (ifid_instr)
   );

`ifdef FETCH_PERF_EN
   // Free-running wrap-around counters of effective stall cycles and flush cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_stall_cycles <= '0;
         perf_flushes      <= '0;
      end else begin
         if (stall && !flush) perf_stall_cycles <= perf_stall_cycles + 32'd1;
         if (flush)           perf_flushes      <= perf_flushes + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle expectations are queued when stimulus
// is driven and compared after the following clock edge.
module tb_fetch_stage;
   import fetch_pkg::*;

   localparam int XLEN = 64;

   typedef struct {
      logic            v;
      logic [XLEN-1:0] pc;
      logic            req;
      logic [XLEN-1:0] addr;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            stall;
   logic            flush;
   logic [XLEN-1:0] branch_target;
   logic            ifid_valid;
   logic [XLEN-1:0] ifid_pc;
   logic [31:0]     ifid_instr;
`ifdef FETCH_PERF_EN
   logic [31:0]     perf_stall_cycles;
   logic [31:0]     perf_flushes;
`endif

   int checks   = 0;
   int failures = 0;
   int exp_stall = 0;
   int exp_flush = 0;
   exp_t exp_q[$];

   fetch_stage_if #(.XLEN(XLEN)) imem_bus ();

   fetch_stage #(
      .XLEN     (XLEN),
      .RESET_PC (64'h0)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .stall         (stall),
      .flush         (flush),
      .branch_target (branch_target),
      .imem          (imem_bus.master),
      .ifid_valid    (ifid_valid),
      .ifid_pc       (ifid_pc),
      .ifid_instr    (ifid_instr)
`ifdef FETCH_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_flushes      (perf_flushes)
`endif
   );

   always #5 clk = ~clk;

   // Distinct, address-derived instruction word so a wrong PC/data pairing is visible.
   function automatic logic [31:0] instr_of(input logic [XLEN-1:0] a);
      return 32'hC0DE0000 ^ a[31:0] ^ {a[63:48], 16'h0};
   endfunction

   task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Drive one cycle of stimulus, queue what the outputs must be after the edge, then compare.
   task automatic cyc(input logic st, input logic fl, input logic [XLEN-1:0] tgt, input logic ak,
                      input logic ev, input logic [XLEN-1:0] epc,
                      input logic ereq, input logic [XLEN-1:0] eaddr);
      exp_t e;
      stall               = st;
      flush               = fl;
      branch_target       = tgt;
      imem_bus.imem_ack   = ak;
      imem_bus.imem_rdata = ak ? instr_of(imem_bus.imem_addr) : 32'hDEADBEEF;
      e.v = ev; e.pc = epc; e.req = ereq; e.addr = eaddr;
      exp_q.push_back(e);
      if (st && !fl) exp_stall++;
      if (fl)        exp_flush++;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("ifid_valid", XLEN'(ifid_valid), XLEN'(e.v));
      if (e.v) chk("ifid_pc", ifid_pc, e.pc);
      chk("ifid_instr", XLEN'(ifid_instr), XLEN'(e.v ? instr_of(e.pc) : NOP_INSTR));
      chk("imem_req", XLEN'(imem_bus.imem_req), XLEN'(e.req));
      chk("imem_addr", imem_bus.imem_addr, e.addr);
   endtask

   initial begin
      reset_n             = 1'b0;
      stall               = 1'b0;
      flush               = 1'b0;
      branch_target       = '0;
      imem_bus.imem_ack   = 1'b0;
      imem_bus.imem_rdata = '0;
      repeat (2) @(posedge clk);
      #1;

      // Reset values
      chk("rst_valid", XLEN'(ifid_valid), 64'd0);
      chk("rst_pc",    ifid_pc, 64'd0);
      chk("rst_instr", XLEN'(ifid_instr), XLEN'(NOP_INSTR));
      chk("rst_req",   XLEN'(imem_bus.imem_req), 64'd1);
      chk("rst_addr",  imem_bus.imem_addr, 64'd0);
`ifdef FETCH_PERF_EN
      chk("rst_perf_stall", XLEN'(perf_stall_cycles), 64'd0);
      chk("rst_perf_flush", XLEN'(perf_flushes), 64'd0);
`endif
      reset_n = 1'b1;

      // Zero-wait streaming: 0, 4, 8
      cyc(0, 0, 0, 1,  1, 64'h0,  1, 64'h4);
      cyc(0, 0, 0, 1,  1, 64'h4,  1, 64'h8);
      cyc(0, 0, 0, 1,  1, 64'h8,  1, 64'hC);

      // Two-cycle stall while 12 is acked: IF/ID holds 8, 12 lands via skid
      cyc(1, 0, 0, 1,  1, 64'h8,  0, 64'h10);
      cyc(1, 0, 0, 0,  1, 64'h8,  0, 64'h10);
      cyc(0, 0, 0, 0,  1, 64'hC,  1, 64'h10);
      cyc(0, 0, 0, 1,  1, 64'h10, 1, 64'h14);
      cyc(0, 0, 0, 1,  1, 64'h14, 1, 64'h18);
      cyc(0, 0, 0, 1,  1, 64'h18, 1, 64'h1C);
      cyc(0, 0, 0, 1,  1, 64'h1C, 1, 64'h20);

      // Flush to 0x100 with the 0x20 request pending; its ack three cycles later is dropped
      cyc(0, 1, 64'h100, 0,  0, 0, 1, 64'h20);
      cyc(0, 0, 0, 0,        0, 0, 1, 64'h20);
      cyc(0, 0, 0, 0,        0, 0, 1, 64'h20);
      cyc(0, 0, 0, 1,        0, 0, 1, 64'h100);
      cyc(0, 0, 0, 1,  1, 64'h100, 1, 64'h104);

      // Enter SKID, then flush+stall together: skid discarded, redirect to 0x200
      cyc(1, 0, 0, 1,        1, 64'h100, 0, 64'h108);
      cyc(1, 1, 64'h200, 0,  0, 0,       1, 64'h200);
      cyc(0, 0, 0, 1,        1, 64'h200, 1, 64'h204);

      // Flush coinciding with ack in FETCH: data discarded, immediate redirect
      cyc(0, 1, 64'h300, 1,  0, 0,       1, 64'h300);
      cyc(0, 0, 0, 1,        1, 64'h300, 1, 64'h304);

      // No ack without stall gives a bubble; no ack with stall holds
      cyc(0, 0, 0, 0,        0, 0,       1, 64'h304);
      cyc(0, 0, 0, 1,        1, 64'h304, 1, 64'h308);
      cyc(1, 0, 0, 0,        1, 64'h304, 1, 64'h308);

      // PC wraps modulo 2^XLEN
      cyc(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1,  0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
      cyc(0, 0, 0, 1,  1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h0);
      cyc(0, 0, 0, 1,  1, 64'h0, 1, 64'h4);

      // Park in SKID with a request history, then pulse reset asynchronously
      cyc(0, 0, 0, 0,  0, 0, 1, 64'h4);
      cyc(1, 0, 0, 1,  0, 0, 0, 64'h8);
      reset_n           = 1'b0;
      stall             = 1'b0;
      imem_bus.imem_ack = 1'b0;
      exp_stall         = 0;
      exp_flush         = 0;
      #1;
      chk("arst_valid", XLEN'(ifid_valid), 64'd0);
      chk("arst_pc",    ifid_pc, 64'd0);
      chk("arst_instr", XLEN'(ifid_instr), XLEN'(NOP_INSTR));
      chk("arst_req",   XLEN'(imem_bus.imem_req), 64'd1);
      chk("arst_addr",  imem_bus.imem_addr, 64'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      cyc(0, 0, 0, 1,  1, 64'h0, 1, 64'h4);

      // Three stall cycles and two flushes for the counters
      cyc(1, 0, 0, 0,       1, 64'h0, 1, 64'h4);
      cyc(1, 0, 0, 0,       1, 64'h0, 1, 64'h4);
      cyc(1, 0, 0, 0,       1, 64'h0, 1, 64'h4);
      cyc(0, 1, 64'h40, 1,  0, 0,     1, 64'h40);
      cyc(0, 1, 64'h80, 0,  0, 0,     1, 64'h40);
`ifdef FETCH_PERF_EN
      chk("perf_stall_cycles", XLEN'(perf_stall_cycles), XLEN'(exp_stall));
      chk("perf_flushes",      XLEN'(perf_flushes),      XLEN'(exp_flush));
`endif

      // A second flush while in DROP replaces the redirect target
      cyc(0, 1, 64'hC0, 0,  0, 0,      1, 64'h40);
      cyc(0, 0, 0, 1,       0, 0,      1, 64'hC0);
      cyc(0, 0, 0, 1,       1, 64'hC0, 1, 64'hC4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
